// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, lane widths, FSM encoding and latency classes
// for the alu_issue_wb slice.
package alu_pkg;
    localparam logic [5:0] VAND   = 6'b000001, VOR    = 6'b000010, VXOR  = 6'b000011,
                           VNOT   = 6'b000100, VMOV   = 6'b000101, VADD  = 6'b000110,
                           VSUB   = 6'b000111, VMULEU = 6'b001000, VMULOU = 6'b001001,
                           VSLL   = 6'b001010, VSRL   = 6'b001011, VSRA  = 6'b001100,
                           VRTTH  = 6'b001101, VDIV   = 6'b001110, VMOD  = 6'b001111,
                           VSQEU  = 6'b010000, VSQOU  = 6'b010001, VSQRT = 6'b010010;
    localparam logic [1:0] WW8 = 2'b00, WW16 = 2'b01, WW32 = 2'b10, WW64 = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV, LAT_ILL} lat_t;

    function automatic lat_t op_latency(input logic [5:0] r_ins);
        return (r_ins inside {VMULEU, VMULOU, VSQEU, VSQOU}) ? LAT_MUL :
               (r_ins inside {VDIV, VMOD, VSQRT})            ? LAT_DIV :
               ((r_ins >= VAND && r_ins <= VSUB) ||
                (r_ins >= VSLL && r_ins <= VRTTH))           ? LAT_ONE : LAT_ILL;
    endfunction

    // Lane boundaries are byte aligned, so wider lanes are zero iff all their bytes are.
    function automatic logic any_lane_zero(input logic [63:0] v, input logic [1:0] ww);
        logic [7:0] b;
        logic [3:0] h;
        logic [1:0] w;
        for (int i = 0; i < 8; i++) b[i] = (v[i*8 +: 8] == 8'd0);
        for (int i = 0; i < 4; i++) h[i] = b[2*i] & b[2*i+1];
        for (int i = 0; i < 2; i++) w[i] = h[2*i] & h[2*i+1];
        return (ww == WW8) ? |b : (ww == WW16) ? |h : (ww == WW32) ? |w : &w;
    endfunction
endpackage

// File: rtl/alu_lat_counter.sv
// alu_lat_counter: loadable down-counter with zero flag, times the ALU occupancy.
module alu_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_count <= '0;
        else if (i_load) r_count <= i_load_val;
        else if (i_dec)  r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issues one instruction to the combinational vector ALU, waits its latency,
// captures the result and hands it to writeback. Optional macro ALU_DIVZERO_CHECK_EN adds wb_divzero.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_rA,
    input  logic [63:0]     in_rB,
    input  logic [5:0]      in_R_ins,
    input  logic [1:0]      in_WW,
    input  logic [RD_W-1:0] in_rD,
    output logic [63:0]     alu_rA,
    output logic [63:0]     alu_rB,
    output logic [5:0]      alu_R_ins,
    output logic            alu_Op_code,
    output logic [1:0]      alu_WW,
    input  logic [63:0]     alu_out,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [63:0]     wb_data,
    output logic [RD_W-1:0] wb_rD,
    output logic            wb_illegal
`ifdef ALU_DIVZERO_CHECK_EN
    ,
    output logic            wb_divzero
`endif
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL) + 1;

    state_t          r_state;
    logic [63:0]     r_rA, r_rB;
    logic [5:0]      r_R_ins;
    logic [1:0]      r_WW;
    logic [RD_W-1:0] r_rD;
    lat_t            w_cls_in;
    logic [CW-1:0]   w_load_val;
    logic            w_zero, w_illegal, w_divzero;
    logic [63:0]     w_result;

    always_comb begin
        w_cls_in   = op_latency(in_R_ins);
        w_load_val = (w_cls_in == LAT_MUL) ? CW'(MUL_LAT - 1) :
                     (w_cls_in == LAT_DIV) ? CW'(DIV_LAT - 1) : '0;
        w_illegal  = (op_latency(r_R_ins) == LAT_ILL);
`ifdef ALU_DIVZERO_CHECK_EN
        w_divzero  = (r_R_ins == VDIV || r_R_ins == VMOD) && any_lane_zero(r_rB, r_WW);
`else
        w_divzero  = 1'b0;
`endif
        w_result   = w_illegal ? '0 : w_divzero ? '1 : alu_out;
    end

    alu_lat_counter #(.W(CW)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_load    (r_state == IDLE && in_valid),
        .i_dec     (r_state == EXEC && !w_zero),
        .i_load_val(w_load_val),
        .o_zero    (w_zero)
    );

    assign in_ready    = (r_state == IDLE);
    assign alu_Op_code = (r_state == EXEC);
    assign alu_rA      = r_rA;
    assign alu_rB      = r_rB;
    assign alu_R_ins   = r_R_ins;
    assign alu_WW      = r_WW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rA       <= '0;
            r_rB       <= '0;
            r_R_ins    <= '0;
            r_WW       <= '0;
            r_rD       <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rD      <= '0;
            wb_illegal <= 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
            wb_divzero <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_rA    <= in_rA;
                    r_rB    <= in_rB;
                    r_R_ins <= in_R_ins;
                    r_WW    <= in_WW;
                    r_rD    <= in_rD;
                    r_state <= EXEC;
                end
                EXEC: if (w_zero) begin
                    wb_data    <= w_result;
                    wb_rD      <= r_rD;
                    wb_illegal <= w_illegal;
                    wb_valid   <= 1'b1;
`ifdef ALU_DIVZERO_CHECK_EN
                    wb_divzero <= w_divzero;
`endif
                    r_state    <= RESP;
                end
                RESP: if (wb_ready) begin
                    wb_valid   <= 1'b0;
                    wb_illegal <= 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
                    wb_divzero <= 1'b0;
`endif
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
